// File: rtl/alu_pkg.sv
// Shared ALU constants and the divider state encoding.
package alu_pkg;
  localparam int ALU_WIDTH = 16;
  localparam logic [ALU_WIDTH-1:0] DIV_ZERO_Q = '1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);
  logic [WIDTH:0] t;

  assign t     = {r, q_msb};
  assign q_bit = (t >= {1'b0, divisor});
  // The compare needs WIDTH+1 bits; a successful difference is below divisor, so WIDTH bits hold it.
  assign r_next = q_bit ? (t[WIDTH-1:0] - divisor) : t[WIDTH-1:0];
endmodule

// File: rtl/alu_div16_seq.sv
// Multi-cycle restoring divider, one quotient bit per cycle.
// DIV_SIGNED_EN selects two's-complement truncating division instead of unsigned.
module alu_div16_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = ALU_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);
  div_state_t       state, state_nxt;
  logic [WIDTH-1:0] r_q, q_q, dvsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] r_next, q_fin;
  logic             q_bit;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
  logic             last;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_q),
    .q_msb  (q_q[WIDTH-1]),
    .divisor(dvsr_q),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  assign q_fin = {q_q[WIDTH-2:0], q_bit};
  assign last  = (cnt_q == CNT_W'(1));

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;

  assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign b_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
  // Sign fix happens on the CALC->DONE edge, so it costs no cycle.
  assign q_fix = neg_q ? -q_fin  : q_fin;
  assign r_fix = neg_r ? -r_next : r_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && start) begin
      neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r <= dividend[WIDTH-1];
    end
  end
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_fix = q_fin;
  assign r_fix = r_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE:    if (start) state_nxt = (divisor == '0) ? DONE : CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q       <= '0;
      q_q       <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (divisor == '0) begin
            quotient  <= {WIDTH{DIV_ZERO_Q[0]}};
            remainder <= dividend;
            div_zero  <= 1'b1;
          end else begin
            r_q      <= '0;
            q_q      <= a_mag;
            dvsr_q   <= b_mag;
            cnt_q    <= CNT_W'(WIDTH);
            div_zero <= 1'b0;
          end
        end
        CALC: begin
          r_q   <= r_next;
          q_q   <= q_fin;
          cnt_q <= cnt_q - CNT_W'(1);
          if (last) begin
            quotient  <= q_fix;
            remainder <= r_fix;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_div16_seq.sv
// Self-checking bench for alu_div16_seq: directed cases plus random pairs against / and %.
module tb_alu_div16_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] quotient, remainder;

  int n_assert = 0;
  int n_fail   = 0;

  alu_div16_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division semantics.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    int sa, sb, iq, ir;
    z = (b == 0);
    if (z) begin
      q = '1;
      r = a;
    end else begin
`ifdef DIV_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
`else
      sa = int'({16'h0, a});
      sb = int'({16'h0, b});
`endif
      iq = sa / sb;
      ir = sa % sb;
      q  = iq[W-1:0];
      r  = ir[W-1:0];
    end
  endtask

  // Issue one operation from a point 1 time unit after a rising edge and check everything.
  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W-1:0] eq, er;
    logic         ez;
    int           cyc, bsy, lat;
    model(a, b, eq, er, ez);
    lat = ez ? 0 : W;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    cyc = 0;
    bsy = busy ? 1 : 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (busy) bsy++;
    end
    check({tag, " latency"}, cyc, lat);
    check({tag, " busy_cycles"}, bsy, lat + 1);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_zero"}, div_zero, ez);
    @(posedge clk); #1;
    check({tag, " done_pulse_len"}, done, 1'b0);
    check({tag, " idle_after"}, busy, 1'b0);
    check({tag, " q_held"}, quotient, eq);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int           dn;

    #2;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset quotient", quotient, 16'h0);
    check("reset remainder", remainder, 16'h0);
    check("reset div_zero", div_zero, 1'b0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    run(16'h0064, 16'h0007, "basic100_7");

    // Reset in the middle of an operation.
    dividend = 16'd100; divisor = 16'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst busy", busy, 1'b0);
    check("midrst done", done, 1'b0);
    check("midrst quotient", quotient, 16'h0);
    check("midrst remainder", remainder, 16'h0);
    check("midrst div_zero", div_zero, 1'b0);
    @(posedge clk); #3 rst_n = 1'b1;
    dn = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) dn++;
      check("midrst idle", busy, 1'b0);
    end
    check("midrst no_done", dn, 0);

    run(16'hFFFF, 16'h0001, "max_by_1");
    run(16'h0003, 16'hFFFF, "small_by_max");
    run(16'h0000, 16'h0005, "zero_dividend");
    run(16'h1234, 16'h0000, "div_by_zero");
    dividend = 16'd8; divisor = 16'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("dz cleared_on_start", div_zero, 1'b0);
    repeat (W) @(posedge clk);
    #1;
    check("after_dz done", done, 1'b1);
    check("after_dz quotient", quotient, 16'd4);
    @(posedge clk); #1;

    // Starts during CALC and in the done cycle are ignored.
    dividend = 16'd100; divisor = 16'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1 dividend = 16'd9; divisor = 16'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    dn = 0;
    while (!done && dn < 40) begin @(posedge clk); #1; dn++; end
    check("ignore first_done_lat", dn, W - 4);
    check("ignore quotient", quotient, 16'd14);
    check("ignore remainder", remainder, 16'd2);
    dividend = 16'd9; divisor = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    check("ignore done_cycle_start", busy, 1'b0);
    check("ignore single_done", done, 1'b0);
    check("ignore q_unchanged", quotient, 16'd14);
    @(posedge clk); #1; start = 1'b0;
    check("accept idle_start", busy, 1'b1);
    repeat (W) @(posedge clk);
    #1;
    check("accept done", done, 1'b1);
    check("accept quotient", quotient, 16'd3);
    check("accept remainder", remainder, 16'd0);
    @(posedge clk); #1;

`ifdef DIV_SIGNED_EN
    run(16'hFFF9, 16'h0002, "s_neg7_2");
    run(16'h0007, 16'hFFFE, "s_7_neg2");
    run(16'h8000, 16'hFFFF, "s_minneg_neg1");
`endif

    for (int k = 0; k < 1000; k++) begin
      ra = W'($urandom);
      rb = (k % 4 == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      run(ra, rb, "random");
      if (n_fail > 50) break;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL timeout: simulation did not finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "timeout");
  end
endmodule
